// File: rtl/core_pkg.sv
// Shared RV32I encodings, ALU operation set and FSM state constants for core.
package core_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_FETCH = 2'd0;
  localparam state_t ST_EXEC  = 2'd1;
  localparam state_t ST_LOAD  = 2'd2;

  // alt selects SUB/SRA; callers decide when instr[30] is meaningful
  function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic alt);
    case (funct3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/mem_intf.sv
// Single-port-style memory bundle: master drives address/data/strobe, slave returns read data.
interface mem_intf (input logic clk);
  logic [31:0] rd_addr;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        wren;

  modport master (input clk, output rd_addr, output wr_addr, output wr_data, output wren, input rd_data);
  modport slave  (input clk, input rd_addr, input wr_addr, input wr_data, input wren, output rd_data);
endinterface

// File: rtl/core_alu.sv
// Combinational RV32I integer ALU.
module core_alu
  import core_pkg::*;
(
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  alu_op_t     alu_op,
  output logic [31:0] result
);

  // select the operation; shifts use only the low five bits of opB
  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = opA + opB;
      ALU_SUB:  result = opA - opB;
      ALU_SLL:  result = opA << opB[4:0];
      ALU_SLT:  result = {31'b0, $signed(opA) < $signed(opB)};
      ALU_SLTU: result = {31'b0, opA < opB};
      ALU_XOR:  result = opA ^ opB;
      ALU_SRL:  result = opA >> opB[4:0];
      ALU_SRA:  result = $unsigned($signed(opA) >>> opB[4:0]);
      ALU_OR:   result = opA | opB;
      ALU_AND:  result = opA & opB;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/core.sv
// Non-pipelined RV32I core: FETCH -> EXEC (-> LOAD) -> FETCH.
module core
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        cpu_rstn,
  output logic [31:0] instr_rd_addr,
  output logic [31:0] instr_wr_addr,
  output logic [31:0] instr_wr_data,
  output logic        instr_wren,
  input  logic [31:0] instr_rd_data,
  output logic [31:0] data_rd_addr,
  output logic [31:0] data_wr_addr,
  output logic [31:0] data_wr_data,
  output logic        data_wren,
  input  logic [31:0] data_rd_data
);

  state_t      state;
  logic [31:0] current_pc;
  logic [31:0] regs [32];
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_off;

  mem_intf imem (.clk(clk));
  mem_intf dmem (.clk(clk));

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] pc_plus4, mem_addr, next_pc, alu_a, alu_b, alu_result;
  logic        in_exec, wr_en, link, is_load, is_sw, taken;
  alu_op_t     alu_op;

  assign instr   = imem.rd_data;
  assign opcode  = instr[6:0];
  assign rd      = instr[11:7];
  assign funct3  = instr[14:12];
  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign pc_plus4 = current_pc + 32'd4;
  // shared rs1+imm adder: load/store effective address and JALR target
  assign mem_addr = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign in_exec  = (state == ST_EXEC);

  // branch condition
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1_val == rs2_val);
      F3_BNE:  taken = (rs1_val != rs2_val);
      F3_BLT:  taken = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: taken = (rs1_val <  rs2_val);
      F3_BGEU: taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  // instruction decode: ALU operands, writeback enable and next pc
  always_comb begin
    alu_a   = rs1_val;
    alu_b   = imm_i;
    alu_op  = ALU_ADD;
    wr_en   = 1'b0;
    link    = 1'b0;
    is_load = 1'b0;
    is_sw   = 1'b0;
    next_pc = pc_plus4;
    case (opcode)
      OPC_LUI:    begin alu_a = '0;         alu_b = imm_u; wr_en = 1'b1; end
      OPC_AUIPC:  begin alu_a = current_pc; alu_b = imm_u; wr_en = 1'b1; end
      OPC_JAL:    begin link = 1'b1; wr_en = 1'b1; next_pc = current_pc + imm_j; end
      OPC_JALR:   begin link = 1'b1; wr_en = 1'b1; next_pc = {mem_addr[31:1], 1'b0}; end
      OPC_BRANCH: if (taken) next_pc = current_pc + imm_b;
      OPC_LOAD:   is_load = 1'b1;
      OPC_STORE:  is_sw = (funct3 == F3_SW);
      OPC_OP_IMM: begin
        alu_op = alu_decode(funct3, (funct3 == F3_SR) && instr[30]);
        wr_en  = 1'b1;
      end
      OPC_OP:     begin alu_b = rs2_val; alu_op = alu_decode(funct3, instr[30]); wr_en = 1'b1; end
      default:    ;
    endcase
  end

  core_alu u_alu (.opA(alu_a), .opB(alu_b), .alu_op(alu_op), .result(alu_result));

  // memory-side outputs are qualified by state so reset forces them low asynchronously
  assign imem.rd_addr = {2'b00, current_pc[31:2]};
  assign imem.wr_addr = '0;
  assign imem.wr_data = '0;
  assign imem.wren    = 1'b0;
  assign imem.rd_data = instr_rd_data;
  assign dmem.rd_addr = (in_exec && is_load) ? {2'b00, mem_addr[31:2]} : '0;
  assign dmem.wr_addr = (in_exec && is_sw)   ? {2'b00, mem_addr[31:2]} : '0;
  assign dmem.wr_data = (in_exec && is_sw)   ? rs2_val : '0;
  assign dmem.wren    = in_exec && is_sw;
  assign dmem.rd_data = data_rd_data;

  assign instr_rd_addr = imem.rd_addr;
  assign instr_wr_addr = imem.wr_addr;
  assign instr_wr_data = imem.wr_data;
  assign instr_wren    = imem.wren;
  assign data_rd_addr  = dmem.rd_addr;
  assign data_wr_addr  = dmem.wr_addr;
  assign data_wr_data  = dmem.wr_data;
  assign data_wren     = dmem.wren;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // little-endian byte/halfword extraction with sign or zero extension
  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = dmem.rd_data[7:0];
      2'd1:    ld_byte = dmem.rd_data[15:8];
      2'd2:    ld_byte = dmem.rd_data[23:16];
      default: ld_byte = dmem.rd_data[31:24];
    endcase
    ld_half = ld_off[1] ? dmem.rd_data[31:16] : dmem.rd_data[15:0];
    case (ld_funct3)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  ld_data = {24'b0, ld_byte};
      F3_LHU:  ld_data = {16'b0, ld_half};
      F3_LW:   ld_data = dmem.rd_data;
      default: ld_data = dmem.rd_data;
    endcase
  end

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  // register-file write port: EXEC results or LOAD data
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rd;
    rf_wdata = link ? pc_plus4 : alu_result;
    if (in_exec && wr_en) begin
      rf_we = 1'b1;
    end else if (state == ST_LOAD) begin
      rf_we    = 1'b1;
      rf_waddr = ld_rd;
      rf_wdata = ld_data;
    end
  end

  // register file; x0 is never written
  always_ff @(posedge clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rf_we && (rf_waddr != 5'd0)) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  // sequencing FSM and pc; pc[1:0] is cleared on every update
  always_ff @(posedge clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state      <= ST_FETCH;
      current_pc <= RESET_PC;
      ld_rd      <= '0;
      ld_funct3  <= '0;
      ld_off     <= '0;
    end else begin
      case (state)
        ST_FETCH: state <= ST_EXEC;
        ST_EXEC: begin
          if (is_load) begin
            state     <= ST_LOAD;
            ld_rd     <= rd;
            ld_funct3 <= funct3;
            ld_off    <= mem_addr[1:0];
          end else begin
            state      <= ST_FETCH;
            current_pc <= {next_pc[31:2], 2'b00};
          end
        end
        ST_LOAD: begin
          state      <= ST_FETCH;
          current_pc <= {pc_plus4[31:2], 2'b00};
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_core.sv
// Self-checking bench for core: directed scenarios plus random programs against an ISS.
module tb_core;

  logic        clk = 1'b0;
  logic        cpu_rstn = 1'b0;
  logic [31:0] instr_rd_addr, instr_wr_addr, instr_wr_data, instr_rd_data;
  logic [31:0] data_rd_addr, data_wr_addr, data_wr_data, data_rd_data;
  logic        instr_wren, data_wren;

  core #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .cpu_rstn(cpu_rstn),
    .instr_rd_addr(instr_rd_addr), .instr_wr_addr(instr_wr_addr),
    .instr_wr_data(instr_wr_data), .instr_wren(instr_wren),
    .instr_rd_data(instr_rd_data),
    .data_rd_addr(data_rd_addr), .data_wr_addr(data_wr_addr),
    .data_wr_data(data_wr_data), .data_wren(data_wren),
    .data_rd_data(data_rd_data)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [256];
  logic [31:0] dmem [64];
  int unsigned wren_cycles;

  // synchronous-read memories, data valid one cycle after address
  always @(posedge clk) begin
    instr_rd_data <= imem[instr_rd_addr[7:0]];
    data_rd_data  <= dmem[data_rd_addr[5:0]];
    if (data_wren) dmem[data_wr_addr[5:0]] <= data_wr_data;
    if (data_wren) wren_cycles++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [2:0] f3, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [12:0] off);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] off);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'h6F};
  endfunction

  // ---------------- reference ISS ----------------
  logic [31:0] mreg [32];
  logic [31:0] mdmem [64];
  int unsigned exp_pc [$];
  int unsigned exp_cyc [$];
  int unsigned model_stores;

  function automatic logic [31:0] alu_model(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return alt ? a - b : a + b;
      3'd1:    return a << b[4:0];
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model_run(input logic [31:0] halt_pc);
    logic [31:0] pc, ins, a, b, ii, si, res, npc, addr, w, sh;
    logic        wr, cond;
    int unsigned cyc, steps;
    pc = 0; steps = 0; model_stores = 0;
    exp_pc.delete(); exp_cyc.delete();
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    while (pc != halt_pc && steps < 500) begin
      ins = imem[pc[9:2]];
      a = mreg[ins[19:15]]; b = mreg[ins[24:20]];
      ii = {{20{ins[31]}}, ins[31:20]};
      si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      npc = pc + 4; wr = 0; res = 0; cyc = 2;
      case (ins[6:0])
        7'h37: begin res = {ins[31:12], 12'h0}; wr = 1; end
        7'h17: begin res = pc + {ins[31:12], 12'h0}; wr = 1; end
        7'h6F: begin res = pc + 4; wr = 1;
                 npc = pc + {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0}; end
        7'h67: begin res = pc + 4; wr = 1; npc = (a + ii) & 32'hFFFF_FFFE; end
        7'h63: begin
          case (ins[14:12])
            3'd0: cond = (a == b);
            3'd1: cond = (a != b);
            3'd4: cond = ($signed(a) < $signed(b));
            3'd5: cond = ($signed(a) >= $signed(b));
            3'd6: cond = (a < b);
            3'd7: cond = (a >= b);
            default: cond = 0;
          endcase
          if (cond) npc = pc + {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        end
        7'h03: begin
          addr = a + ii; w = mdmem[addr[7:2]]; cyc = 3; wr = 1;
          case (ins[14:12])
            3'd0: begin sh = w >> (addr[1:0] * 8); res = {{24{sh[7]}}, sh[7:0]}; end
            3'd1: begin sh = w >> (addr[1] * 16);  res = {{16{sh[15]}}, sh[15:0]}; end
            3'd4: begin sh = w >> (addr[1:0] * 8); res = {24'h0, sh[7:0]}; end
            3'd5: begin sh = w >> (addr[1] * 16);  res = {16'h0, sh[15:0]}; end
            default: res = w;
          endcase
        end
        7'h23: if (ins[14:12] == 3'd2) begin
          addr = a + si; mdmem[addr[7:2]] = b; model_stores++;
        end
        7'h13: begin wr = 1; res = alu_model(ins[14:12], ins[14:12] == 3'd5 && ins[30], a, ii); end
        7'h33: begin wr = 1; res = alu_model(ins[14:12], ins[30], a, b); end
        default: ;
      endcase
      if (wr && ins[11:7] != 0) mreg[ins[11:7]] = res;
      pc = npc & 32'hFFFF_FFFC;
      exp_pc.push_back(pc); exp_cyc.push_back(cyc);
      steps++;
    end
  endtask

  // ---------------- random program generator ----------------
  logic [2:0] ld_f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0] br_f3s [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [31:0] nops [5] = '{32'h0000_000F, 32'h0000_0073, 32'h0010_0073, 32'h0000_000B, 32'h0000_007B};

  task automatic build_random(input int unsigned n);
    logic [31:0] ins;
    logic [4:0]  rd, r1, r2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [6:0]  f7;
    int unsigned kind, k, span;
    for (int unsigned i = 0; i < 256; i++) imem[i] = '0;
    for (int unsigned i = 0; i < n; i++) begin
      kind = $urandom_range(0, 9);
      rd = 5'($urandom_range(0, 15)); r1 = 5'($urandom_range(0, 15)); r2 = 5'($urandom_range(0, 15));
      f3 = 3'($urandom_range(0, 7)); imm = 12'($urandom);
      span = n - i; k = $urandom_range(1, (span > 3) ? 3 : span);
      case (kind)
        0, 1, 2: begin
          if (f3 == 3'd1) imm = {7'h00, imm[4:0]};
          if (f3 == 3'd5) imm = {1'b0, imm[10], 5'h00, imm[4:0]};
          ins = enc_i(7'h13, rd, f3, r1, imm);
        end
        3, 4: begin
          f7 = ((f3 == 3'd0 || f3 == 3'd5) && imm[0]) ? 7'h20 : 7'h00;
          ins = enc_r(f7, r2, r1, f3, rd);
        end
        5: ins = enc_u(imm[0] ? 7'h37 : 7'h17, rd, 20'($urandom));
        6: ins = enc_i(7'h03, rd, ld_f3s[$urandom_range(0, 4)], 5'd0, 12'($urandom_range(0, 255)));
        7: ins = enc_s(imm[0] ? 3'd2 : {2'b00, imm[1]}, 5'd0, r2, 12'($urandom_range(0, 255)));
        8: case (imm[1:0])
          2'd2:    ins = enc_j(rd, 21'(4 * k));
          2'd3:    ins = enc_i(7'h67, rd, 3'd0, 5'd0, 12'(4 * (i + k) + $urandom_range(0, 3)));
          default: ins = enc_b(br_f3s[$urandom_range(0, 5)], r1, r2, 13'(4 * k));
        endcase
        default: ins = nops[$urandom_range(0, 4)];
      endcase
      imem[i] = ins;
    end
    imem[n] = enc_j(5'd0, 21'd0);
  endtask

  // hold reset, check reset outputs, release on a falling edge
  task automatic do_reset();
    cpu_rstn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_pc", dut.current_pc, 32'h0);
    check_eq("rst_iaddr", instr_rd_addr, 32'h0);
    check_eq("rst_wren", {31'b0, data_wren}, 32'h0);
    check_eq("rst_daddr", data_rd_addr | data_wr_addr | data_wr_data, 32'h0);
    wren_cycles = 0;
    cpu_rstn = 1'b1;
    #1;
    check_eq("first_iaddr", instr_rd_addr, 32'h0);
    check_eq("first_pc", dut.current_pc, 32'h0);
  endtask

  task automatic load_directed();
    for (int unsigned i = 0; i < 256; i++) imem[i] = '0;
    for (int unsigned i = 0; i < 64; i++) dmem[i] = '0;
    imem[0] = enc_i(7'h13, 5'd1, 3'd0, 5'd0, 12'd5);       // ADDI x1,x0,5
    imem[1] = enc_i(7'h13, 5'd2, 3'd0, 5'd1, 12'hFFD);     // ADDI x2,x1,-3
    imem[2] = enc_i(7'h03, 5'd3, 3'd0, 5'd0, 12'd9);       // LB x3,9(x0)
    imem[3] = enc_s(3'd2, 5'd0, 5'd2, 12'd8);              // SW x2,8(x0)
    imem[4] = enc_j(5'd1, 21'd16);                         // JAL x1,+16
    imem[6] = enc_j(5'd0, 21'd0);                          // 0x18: halt
    imem[8] = enc_b(3'd0, 5'd0, 5'd0, 13'h1FF8);           // 0x20: BEQ x0,x0,-8
    dmem[2] = 32'h0000_80FF;
  endtask

  logic [31:0] exp_dir [13] = '{32'h0, 32'h4, 32'h4, 32'h8, 32'h8, 32'h8, 32'hC, 32'hC,
                                32'h10, 32'h10, 32'h20, 32'h20, 32'h18};

  initial begin
    int unsigned cycles;
    logic [31:0] old;
    // directed sequence
    cpu_rstn = 1'b0;
    load_directed();
    do_reset();
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      check_eq($sformatf("dir_pc_%0d", k), dut.current_pc, exp_dir[k-1]);
      if (k == 5) check_eq("lb_rd_addr", data_rd_addr, 32'd2);
      if (k == 7 || k == 9) check_eq("sw_wren_off", {31'b0, data_wren}, 32'd0);
      if (k == 8) begin
        check_eq("sw_wren", {31'b0, data_wren}, 32'd1);
        check_eq("sw_addr", data_wr_addr, 32'd2);
        check_eq("sw_data", data_wr_data, 32'd2);
      end
    end
    check_eq("x1", dut.regs[1], 32'h14);
    check_eq("x2", dut.regs[2], 32'h2);
    check_eq("x3", dut.regs[3], 32'hFFFF_FF80);
    check_eq("mem2", dmem[2], 32'h2);
    check_eq("wren_cycles", wren_cycles, 32'd1);

    // reset during EXEC of SW aborts it
    cpu_rstn = 1'b0;
    load_directed();
    do_reset();
    repeat (8) @(posedge clk);
    #1;
    check_eq("abort_pre_wren", {31'b0, data_wren}, 32'd1);
    cpu_rstn = 1'b0;
    #1;
    check_eq("abort_wren", {31'b0, data_wren}, 32'd0);
    check_eq("abort_pc", dut.current_pc, 32'h0);
    check_eq("abort_iaddr", instr_rd_addr, 32'h0);
    for (int i = 0; i < 32; i++) check_eq($sformatf("abort_x%0d", i), dut.regs[i], 32'h0);
    @(posedge clk); #1;
    check_eq("abort_mem2", dmem[2], 32'h0000_80FF);

    // random programs against the ISS
    for (int t = 0; t < 4; t++) begin
      cpu_rstn = 1'b0;
      build_random(40);
      for (int i = 0; i < 64; i++) begin dmem[i] = $urandom; mdmem[i] = dmem[i]; end
      model_run(32'd160);
      do_reset();
      foreach (exp_pc[j]) begin
        cycles = 0;
        old = dut.current_pc;
        while (dut.current_pc == old && cycles < 8) begin
          @(posedge clk); #1;
          cycles++;
        end
        check_eq($sformatf("t%0d_pc_%0d", t, j), dut.current_pc, exp_pc[j]);
        check_eq($sformatf("t%0d_cyc_%0d", t, j), cycles, exp_cyc[j]);
        if (cycles >= 8) break;
      end
      for (int i = 1; i < 32; i++) check_eq($sformatf("t%0d_x%0d", t, i), dut.regs[i], mreg[i]);
      for (int i = 0; i < 64; i++) check_eq($sformatf("t%0d_mem%0d", t, i), dmem[i], mdmem[i]);
      check_eq($sformatf("t%0d_stores", t), wren_cycles, model_stores);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
